// File: rtl/sd_host_pkg.sv
// Shared types and widths for the SD host register-bus side and the DMA side.
package sd_host_pkg;
  localparam int BUS_DW = 32;
  localparam int STRB_W = BUS_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/sd_strb_expand.sv
// Byte strobes to a per-bit write mask; one 8-bit lane per strobe bit.
module sd_strb_expand
  import sd_host_pkg::*;
(
  input  logic [STRB_W-1:0] strb,
  output logic [BUS_DW-1:0] mask
);
  for (genvar k = 0; k < STRB_W; k++) begin : g_lane
    assign mask[8*k +: 8] = {8{strb[k]}};
  end
endmodule

// File: rtl/sd_reg_bus_slave.sv
// Host-bus responder for the SD register bank: one request in flight, a single
// ACCESS cycle that pulses the bank write port, then a held response.
module sd_reg_bus_slave
  import sd_host_pkg::*;
#(
  parameter int                   NUM_WORDS = 64,
  parameter int                   ADDR_W    = 8,
  parameter logic [NUM_WORDS-1:0] RO_WORDS  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [BUS_DW-1:0]            req_wdata,
  input  logic [STRB_W-1:0]            req_strb,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [BUS_DW-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic [$clog2(NUM_WORDS)-1:0] reg_wr_sel,
  output logic [BUS_DW-1:0]            reg_wr_data,
  output logic [BUS_DW-1:0]            reg_wr_enb,
  input  logic [BUS_DW*NUM_WORDS-1:0]  reg_rd_bus
);
  localparam int SEL_W = $clog2(NUM_WORDS);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [BUS_DW-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } req_t;

  state_t            state_q, state_d;
  req_t              cap_q, cap_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic              rerr_q, rerr_d;
  logic [BUS_DW-1:0] rdata_q, rdata_d;

  logic [SEL_W-1:0]  word;
  logic              in_range, err, wr_fire;
  logic [BUS_DW-1:0] strb_mask;

  // Decode works on the captured request only, so it is stable through ACCESS.
  assign word     = cap_q.addr[SEL_W+1:2];
  assign in_range = 32'(cap_q.addr) < 32'(NUM_WORDS * 4);
  assign err      = !in_range || (cap_q.addr[1:0] != 2'b00) ||
                    (cap_q.write && in_range && RO_WORDS[word]);
  assign wr_fire  = (state_q == ST_ACCESS) && cap_q.write && !err;

  sd_strb_expand u_strb (
    .strb (cap_q.strb),
    .mask (strb_mask)
  );

  // Gated by the async-reset state, so the pulse drops the moment reset asserts.
  assign reg_wr_sel  = wr_fire ? word        : '0;
  assign reg_wr_data = wr_fire ? cap_q.wdata : '0;
  assign reg_wr_enb  = wr_fire ? strb_mask   : '0;

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    rerr_d   = rerr_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          cap_d   = '{write: req_write, addr: req_addr, wdata: req_wdata, strb: req_strb};
          ready_d = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        rvalid_d = 1'b1;
        rerr_d   = err;
        rdata_d  = (!cap_q.write && !err) ? reg_rd_bus[word*BUS_DW +: BUS_DW] : '0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          rerr_d   = 1'b0;
          rdata_d  = '0;
          ready_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cap_d    = '0;
        ready_d  = 1'b0;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cap_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_sd_reg_bus_slave.sv
// Bench for sd_reg_bus_slave: drives bus transactions against a word-array model of the bank.
module tb_sd_reg_bus_slave;
  localparam int          NW = 64;
  localparam int          AW = 9;
  localparam logic [63:0] RO = 64'h0000_0100_0000_0020;  // words 5 and 40

  logic            clk, reset;
  logic            req_valid, req_ready, req_write;
  logic [AW-1:0]   req_addr;
  logic [31:0]     req_wdata;
  logic [3:0]      req_strb;
  logic            resp_valid, resp_ready, resp_err;
  logic [31:0]     resp_rdata;
  logic [5:0]      reg_wr_sel;
  logic [31:0]     reg_wr_data, reg_wr_enb;
  logic [32*NW-1:0] bank_bus;
  logic            bank_clr;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] mem [NW];

  sd_reg_bus_slave #(.NUM_WORDS(NW), .ADDR_W(AW), .RO_WORDS(RO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
    .reg_wr_enb(reg_wr_enb), .reg_rd_bus(bank_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank as the surrounding design builds it: masked read-modify-write.
  always @(posedge clk) begin
    if (bank_clr) bank_bus <= {NW{32'hFFFF_FFFF}};
    else bank_bus[32*int'(reg_wr_sel) +: 32] <=
           (bank_bus[32*int'(reg_wr_sel) +: 32] & ~reg_wr_enb) | (reg_wr_data & reg_wr_enb);
  end

  function automatic logic [31:0] mask_of(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic bit err_of(input bit w, input int a);
    if (a >= NW * 4) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    return w && RO[a / 4];
  endfunction

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mem[a / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  // One transaction with resp_ready held high; entered and left on a negedge.
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output logic rv, output logic [31:0] enb_o, output logic [5:0] sel_o,
                      output logic [31:0] wd_o, output logic [31:0] enb_late,
                      output int acc, output bit to);
    int k;
    to = 0; rd = '0; er = 0; rv = 0; enb_o = '0; sel_o = '0; wd_o = '0; enb_late = '0; acc = -1;
    req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1; resp_ready = 1;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (req_ready !== 1'b1) begin to = 1; req_valid = 0; return; end
    acc = cyc;
    @(negedge clk);
    req_valid = 0; enb_o = reg_wr_enb; sel_o = reg_wr_sel; wd_o = reg_wr_data;
    @(negedge clk);
    rv = resp_valid; rd = resp_rdata; er = resp_err; enb_late = reg_wr_enb;
    @(negedge clk);
    enb_late |= reg_wr_enb;
  endtask

  task automatic test_reset();
    reset = 0; bank_clr = 1; req_valid = 0; req_write = 0; req_addr = '0;
    req_wdata = '0; req_strb = '0; resp_ready = 0;
    for (int i = 0; i < NW; i++) mem[i] = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, reg_wr_enb, reg_wr_data, reg_wr_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rd=%h enb=%h wd=%h sel=%h, want all 0",
               req_ready, resp_valid, resp_err, resp_rdata, reg_wr_enb, reg_wr_data, reg_wr_sel);
    end
    bank_clr = 0; reset = 1;
    #1;
    n_chk++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", req_ready); end
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", req_ready); end
  endtask

  task automatic test_write_full();
    logic [31:0] rd, enb_o, wd_o, el; logic er, rv; logic [5:0] sel_o; int acc; bit to;
    xfer(1, 9'h004, 32'hA5A5_1234, 4'hF, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
    model_write(4, 32'hA5A5_1234, 4'hF);
    n_chk++;
    if (to || {sel_o, enb_o, wd_o} !== {6'd1, 32'hFFFF_FFFF, 32'hA5A5_1234}) begin
      n_fail++; $display("FAIL wr04_port: got to=%b sel=%0d enb=%h wd=%h want sel=1 enb=ffffffff wd=a5a51234",
                         to, sel_o, enb_o, wd_o);
    end
    n_chk++;
    if ({rv, er, rd, el} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL wr04_resp: got vld=%b err=%b rd=%h late_enb=%h want 1 0 0 0", rv, er, rd, el);
    end
    xfer(0, 9'h004, 32'h0, 4'h0, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
    n_chk++;
    if (to || {rv, er, rd, enb_o} !== {1'b1, 1'b0, mem[1], 32'h0}) begin
      n_fail++; $display("FAIL rd04: got to=%b vld=%b err=%b rd=%h enb=%h want rd=%h", to, rv, er, rd, enb_o, mem[1]);
    end
  endtask

  task automatic test_write_strobe();
    logic [31:0] rd, enb_o, wd_o, el; logic er, rv; logic [5:0] sel_o; int acc; bit to;
    xfer(1, 9'h008, 32'h1122_3344, 4'b0101, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
    model_write(8, 32'h1122_3344, 4'b0101);
    n_chk++;
    if (to || {er, sel_o, enb_o} !== {1'b0, 6'd2, 32'h00FF_00FF}) begin
      n_fail++; $display("FAIL wr08_strb: got to=%b err=%b sel=%0d enb=%h want 0 2 00ff00ff", to, er, sel_o, enb_o);
    end
    xfer(0, 9'h008, 32'h0, 4'h0, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
    n_chk++;
    if (to || rd !== 32'hFF22_FF44 || mem[2] !== 32'hFF22_FF44) begin
      n_fail++; $display("FAIL rd08_merge: got to=%b rd=%h want ff22ff44", to, rd);
    end
    xfer(1, 9'h00C, 32'hDEAD_BEEF, 4'h0, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
    n_chk++;
    if (to || {rv, er, enb_o} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL wr_nostrb: got to=%b vld=%b err=%b enb=%h want 1 0 0", to, rv, er, enb_o);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, enb_o, wd_o, el; logic er, rv; logic [5:0] sel_o; int acc; bit to;
    logic [AW-1:0] bad [4];
    bit wr [4];
    bad[0] = 9'h101; bad[1] = 9'h100; bad[2] = 9'h005; bad[3] = 9'h014;
    wr[0] = 0; wr[1] = 0; wr[2] = 1; wr[3] = 1;
    for (int i = 0; i < 4; i++) begin
      xfer(wr[i], bad[i], 32'h1234_5678, 4'hF, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
      n_chk++;
      if (to || {rv, er, rd, enb_o, el} !== {1'b1, 1'b1, 32'h0, 32'h0, 32'h0}) begin
        n_fail++; $display("FAIL err_access addr=%h w=%b: got to=%b vld=%b err=%b rd=%h enb=%h want 1 1 0 0",
                           bad[i], wr[i], to, rv, er, rd, enb_o);
      end
    end
    xfer(0, 9'h014, 32'h0, 4'h0, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
    n_chk++;
    if (to || {er, rd} !== {1'b0, mem[5]}) begin
      n_fail++; $display("FAIL ro_unchanged: got to=%b err=%b rd=%h want 0 %h", to, er, rd, mem[5]);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    req_write = 0; req_addr = 9'h000; req_valid = 1; resp_ready = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    req_addr = 9'h004;  // second request held by the master during the stall
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({resp_valid, resp_rdata, req_ready} !== {1'b1, mem[0], 1'b0}) begin
        n_fail++; $display("FAIL stall_hold cyc%0d: got vld=%b rd=%h rdy=%b want 1 %h 0",
                           i, resp_valid, resp_rdata, req_ready, mem[0]);
      end
      @(negedge clk);
    end
    resp_ready = 1;
    @(negedge clk);
    n_chk++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 0;
    n_chk++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL second_accept: got rdy=%b want 0", req_ready); end
    @(negedge clk);
    n_chk++;
    if ({resp_valid, resp_rdata} !== {1'b1, mem[1]}) begin
      n_fail++; $display("FAIL second_resp: got vld=%b rd=%h want 1 %h", resp_valid, resp_rdata, mem[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, enb_o, wd_o, el; logic er, rv; logic [5:0] sel_o; int acc; bit to;
    int k = 0;
    req_write = 0; req_addr = 9'h004; req_valid = 1; resp_ready = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk); req_valid = 0;
    @(negedge clk);
    #2 reset = 0;
    #1;
    n_chk++;
    if ({resp_valid, req_ready, resp_rdata, reg_wr_enb} !== '0) begin
      n_fail++; $display("FAIL rst_in_resp: got vld=%b rdy=%b rd=%h enb=%h want 0", resp_valid, req_ready, resp_rdata, reg_wr_enb);
    end
    @(negedge clk); reset = 1;
    @(negedge clk);
    k = 0;
    req_write = 1; req_addr = 9'h00C; req_wdata = $urandom; req_strb = 4'hF; req_valid = 1; resp_ready = 1;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk); req_valid = 0;
    n_chk++;
    if (reg_wr_enb !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL access_enb: got %h want ffffffff", reg_wr_enb); end
    #2 reset = 0;
    #1;
    n_chk++;
    if (reg_wr_enb !== 32'h0) begin n_fail++; $display("FAIL rst_in_access_enb: got %h want 0", reg_wr_enb); end
    @(negedge clk); reset = 1;
    n_chk++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_rdy: got %b want 0", req_ready); end
    @(negedge clk);
    xfer(0, 9'h00C, 32'h0, 4'h0, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
    n_chk++;
    if (to || {rv, er, rd} !== {1'b1, 1'b0, mem[3]}) begin
      n_fail++; $display("FAIL aborted_write: got to=%b vld=%b err=%b rd=%h want 1 0 %h", to, rv, er, rd, mem[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, enb_o, wd_o, el, d; logic er, rv; logic [5:0] sel_o; logic [3:0] s;
    int acc, prev, w; bit to;
    int words [8];
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      do w = $urandom_range(0, NW - 1); while (RO[w]);
      words[i] = w; d = $urandom; s = 4'($urandom);
      xfer(1, AW'(4 * w), d, s, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
      model_write(4 * w, d, s);
      n_chk++;
      if (to || {rv, er, int'(sel_o), enb_o, wd_o, el} !== {1'b1, 1'b0, w, mask_of(s), d, 32'h0}) begin
        n_fail++; $display("FAIL b2b_wr%0d: got to=%b err=%b sel=%0d enb=%h wd=%h late=%h want sel=%0d enb=%h wd=%h",
                           i, to, er, sel_o, enb_o, wd_o, el, w, mask_of(s), d);
      end
      if (i > 0) begin
        n_chk++;
        if (acc - prev != 3) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, acc - prev); end
      end
      prev = acc;
    end
    for (int i = 0; i < 8; i++) begin
      xfer(0, AW'(4 * words[i]), 32'h0, 4'h0, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
      n_chk++;
      if (to || {er, rd} !== {1'b0, mem[words[i]]}) begin
        n_fail++; $display("FAIL b2b_rd%0d: got to=%b err=%b rd=%h want %h", i, to, er, rd, mem[words[i]]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, enb_o, wd_o, el, d, exp_rd, exp_enb; logic er, rv; logic [5:0] sel_o; logic [3:0] s;
    int acc, a; bit to, w, e;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom); d = $urandom; s = 4'($urandom);
      a = ($urandom_range(0, 9) < 7) ? 4 * $urandom_range(0, NW - 1) : $urandom_range(0, 511);
      e = err_of(w, a);
      exp_rd  = (w || e) ? 32'h0 : mem[a / 4];
      exp_enb = (w && !e) ? mask_of(s) : 32'h0;
      xfer(w, AW'(a), d, s, rd, er, rv, enb_o, sel_o, wd_o, el, acc, to);
      if (w && !e) model_write(a, d, s);
      n_chk++;
      if (to || {rv, er, rd, enb_o} !== {1'b1, e, exp_rd, exp_enb}) begin
        n_fail++; $display("FAIL rand%0d w=%b a=%h: got to=%b vld=%b err=%b rd=%h enb=%h want 1 %b %h %h",
                           i, w, a, to, rv, er, rd, enb_o, e, exp_rd, exp_enb);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_full();
    test_write_strobe();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
